btn_event_ctrl: RTL and testbench

//  Bus-mapped controller for up to 16 push-buttons on the I/O peripheral bus.
//  Per button: synchronises the raw input, debounces it, and latches press events into a sticky pending register.

---
 rtl/btn_event_ctrl_if.sv | 20 ++
 rtl/btn_event_ctrl.sv | 114 +++++++++++
 tb/tb_btn_event_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/btn_event_ctrl_if.sv
// Peripheral bus shared by the DispositivosInOut devices: chip select,
// write enable, register select, write data, registered read data and irq.
interface btn_event_ctrl_if;
  logic        cs;
  logic        we;
  logic [1:0]  reg_sel;
  logic [15:0] in;
  logic [15:0] out;
  logic        irq;

  modport master (
    output cs, we, reg_sel, in,
    input  out, irq
  );

  modport slave (
    input  cs, we, reg_sel, in,
    output out, irq
  );
endinterface

// File: rtl/btn_event_ctrl.sv
// Push-button controller: per-button 2-FF synchroniser and debouncer,
// sticky press-pending register (W1C), interrupt mask, saturating press
// counter, all exposed on the shared cs/we/reg_sel/in/out bus.
module btn_event_ctrl #(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  btn_event_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] sync1_q, sync1_d;
  logic [N_BTN-1:0] sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q [N_BTN];
  logic [CNT_W-1:0] cnt_d [N_BTN];
  logic [N_BTN-1:0] stable_q, stable_d;
  logic [N_BTN-1:0] pend_q, pend_d;
  logic [N_BTN-1:0] mask_q, mask_d;
  logic [15:0]      evt_q, evt_d;
  logic [15:0]      out_q, out_d;
  logic             irq_q, irq_d;

  logic [N_BTN-1:0] press;
  logic [4:0]       press_cnt;
  logic             wr_en;
  logic             rd_en;
  logic [N_BTN-1:0] w1c;
  logic [15:0]      evt_base;
  logic [16:0]      evt_sum;
  logic [15:0]      rdata;

  // Synchronise raw pins and debounce: a level is accepted only after
  // DEBOUNCE_CYCLES consecutive cycles of disagreement with the stable level.
  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    press     = stable_d & ~stable_q;
    press_cnt = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      press_cnt = press_cnt + 5'(press[i]);
    end
  end

  // Register file update, read mux and interrupt generation.
  // Reads use pre-edge register values; a press always beats a W1C on the
  // same bit, and a counter clear still absorbs that cycle's presses.
  always_comb begin
    wr_en    = bus.cs & bus.we;
    rd_en    = bus.cs & ~bus.we;
    w1c      = (wr_en && bus.reg_sel == 2'd1) ? bus.in[N_BTN-1:0] : '0;
    pend_d   = (pend_q & ~w1c) | press;
    mask_d   = (wr_en && bus.reg_sel == 2'd2) ? bus.in[N_BTN-1:0] : mask_q;
    evt_base = (wr_en && bus.reg_sel == 2'd3) ? '0 : evt_q;
    evt_sum  = 17'(evt_base) + 17'(press_cnt);
    evt_d    = evt_sum[16] ? '1 : evt_sum[15:0];
    case (bus.reg_sel)
      2'd0:    rdata = 16'(stable_q);
      2'd1:    rdata = 16'(pend_q);
      2'd2:    rdata = 16'(mask_q);
      default: rdata = evt_q;
    endcase
    out_d = rd_en ? rdata : '0;
    irq_d = |(pend_q & mask_q);
  end

  // State registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      pend_q   <= '0;
      mask_q   <= '0;
      evt_q    <= '0;
      out_q    <= '0;
      irq_q    <= 1'b0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      evt_q    <= evt_d;
      out_q    <= out_d;
      irq_q    <= irq_d;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.out = out_q;
  assign bus.irq = irq_q;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Bench for btn_event_ctrl: sample-history reference model checked every
// cycle, directed scenarios with literal expectations, and a second fast
// debounce instance used to drive the press counter into saturation.
module tb_btn_event_ctrl;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_raw;
  logic [3:0] btn_raw2;
  int         n_cmp = 0;
  int         n_err = 0;

  btn_event_ctrl_if bus ();
  btn_event_ctrl_if bus2 ();

  btn_event_ctrl #(.N_BTN(4), .DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .bus(bus)
  );

  btn_event_ctrl #(.N_BTN(4), .DEBOUNCE_CYCLES(2), .CNT_W(1)) dut2 (
    .clk(clk), .reset(reset), .btn_raw(btn_raw2), .bus(bus2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a level is accepted when the last D synchronised
  // samples (raw samples from 2..D+1 edges ago) all oppose the stable level.
  logic [3:0]  m_hist [0:7];
  logic [3:0]  m_stable, m_pend, m_mask;
  logic [15:0] m_evt, m_out;
  logic        m_irq;

  always @(posedge clk or posedge reset) begin
    logic [3:0]  ns, press, clr;
    logic        flip;
    int unsigned sum;
    if (reset) begin
      for (int j = 0; j < 8; j++) m_hist[j] = '0;
      m_stable = '0; m_pend = '0; m_mask = '0;
      m_evt = '0; m_out = '0; m_irq = 1'b0;
    end else begin
      ns = m_stable;
      for (int b = 0; b < 4; b++) begin
        flip = 1'b1;
        for (int k = 1; k <= D; k++) if (m_hist[k][b] == m_stable[b]) flip = 1'b0;
        if (flip) ns[b] = ~m_stable[b];
      end
      press = ns & ~m_stable;
      if (bus.cs && !bus.we)
        case (bus.reg_sel)
          2'd0: m_out = {12'h0, m_stable};
          2'd1: m_out = {12'h0, m_pend};
          2'd2: m_out = {12'h0, m_mask};
          default: m_out = m_evt;
        endcase
      else m_out = '0;
      m_irq = |(m_pend & m_mask);
      clr = (bus.cs && bus.we && bus.reg_sel == 2'd1) ? bus.in[3:0] : 4'h0;
      m_pend = (m_pend & ~clr) | press;
      if (bus.cs && bus.we && bus.reg_sel == 2'd2) m_mask = bus.in[3:0];
      sum = ((bus.cs && bus.we && bus.reg_sel == 2'd3) ? 0 : int'(m_evt)) + $countones(press);
      m_evt = (sum > 65535) ? 16'hFFFF : 16'(sum);
      for (int j = 7; j > 0; j--) m_hist[j] = m_hist[j-1];
      m_hist[0] = btn_raw;
      m_stable = ns;
    end
  end

  // Every-cycle comparison of the registered outputs against the model.
  always @(negedge clk) begin
    if (!reset) begin
      chk("model_out", bus.out, m_out);
      chk("model_irq", {15'h0, bus.irq}, {15'h0, m_irq});
    end
  end

  task automatic rd(input logic [1:0] sel, output logic [15:0] v);
    bus.cs = 1'b1; bus.we = 1'b0; bus.reg_sel = sel;
    @(negedge clk);
    v = bus.out;
    bus.cs = 1'b0;
  endtask

  task automatic wr(input logic [1:0] sel, input logic [15:0] d);
    bus.cs = 1'b1; bus.we = 1'b1; bus.reg_sel = sel; bus.in = d;
    @(negedge clk);
    bus.cs = 1'b0; bus.we = 1'b0;
  endtask

  task automatic rd2(input logic [1:0] sel, output logic [15:0] v);
    bus2.cs = 1'b1; bus2.we = 1'b0; bus2.reg_sel = sel;
    @(negedge clk);
    v = bus2.out;
    bus2.cs = 1'b0;
  endtask

  task automatic group2();
    btn_raw2 = 4'hF;
    repeat (2) @(negedge clk);
    btn_raw2 = 4'h0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] v;
    reset = 1'b1;
    btn_raw = '0; btn_raw2 = '0;
    bus.cs = 0; bus.we = 0; bus.reg_sel = '0; bus.in = '0;
    bus2.cs = 0; bus2.we = 0; bus2.reg_sel = '0; bus2.in = '0;
    repeat (2) @(negedge clk);
    chk("reset_out", bus.out, 16'h0);
    chk("reset_irq", {15'h0, bus.irq}, 16'h0);
    reset = 1'b0;
    for (int r = 0; r < 4; r++) begin
      rd(2'(r), v);
      chk("reset_reg", v, 16'h0);
    end

    // Clean press on button 0 with its interrupt enabled
    wr(2'd2, 16'h0001);
    btn_raw = 4'b0001;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 6) begin
        chk("press_irq_e6", {15'h0, bus.irq}, 16'h0);
        bus.cs = 1'b1; bus.we = 1'b0; bus.reg_sel = 2'd1;
      end
      if (k == 7) begin
        chk("press_irq_e7", {15'h0, bus.irq}, 16'h1);
        chk("press_pending", bus.out, 16'h0001);
        bus.cs = 1'b0;
      end
    end
    rd(2'd3, v); chk("press_evt", v, 16'h0001);
    rd(2'd0, v); chk("press_status", v, 16'h0001);

    // Bounce on button 1: 3 high, 1 low, 3 high, low
    btn_raw = 4'b0011; repeat (3) @(negedge clk);
    btn_raw = 4'b0001; @(negedge clk);
    btn_raw = 4'b0011; repeat (3) @(negedge clk);
    btn_raw = 4'b0001; repeat (8) @(negedge clk);
    rd(2'd0, v); chk("bounce_status", v, 16'h0001);
    rd(2'd1, v); chk("bounce_pending", v, 16'h0001);
    rd(2'd3, v); chk("bounce_evt", v, 16'h0001);

    // W1C racing a press acceptance on the same edge
    btn_raw = 4'b0000; repeat (8) @(negedge clk);
    wr(2'd1, 16'h0001);
    repeat (2) @(negedge clk);
    btn_raw = 4'b0001;
    for (int k = 1; k <= 5; k++) @(negedge clk);
    bus.cs = 1'b1; bus.we = 1'b1; bus.reg_sel = 2'd1; bus.in = 16'h0001;
    @(negedge clk);
    bus.cs = 1'b0; bus.we = 1'b0;
    rd(2'd1, v); chk("race_pending", v, 16'h0001);
    wr(2'd1, 16'h0001);
    chk("w1c_irq_hold", {15'h0, bus.irq}, 16'h1);
    @(negedge clk);
    chk("w1c_irq_fall", {15'h0, bus.irq}, 16'h0);
    rd(2'd1, v); chk("w1c_pending", v, 16'h0000);

    // All four buttons pressed together
    btn_raw = 4'b0000; repeat (8) @(negedge clk);
    btn_raw = 4'b1111; repeat (8) @(negedge clk);
    rd(2'd3, v); chk("multi_evt", v, 16'h0006);
    rd(2'd1, v); chk("multi_pending", v, 16'h000F);

    // Bus read timing, STATUS write ignored, upper bits dropped
    wr(2'd2, 16'h000A);
    bus.cs = 1'b1; bus.we = 1'b0; bus.reg_sel = 2'd2;
    @(negedge clk);
    chk("bus_read_mask", bus.out, 16'h000A);
    bus.cs = 1'b0;
    @(negedge clk);
    chk("bus_read_idle", bus.out, 16'h0000);
    wr(2'd0, 16'hFFFF);
    rd(2'd0, v); chk("status_write_ignored", v, 16'h000F);
    wr(2'd2, 16'hFFFF);
    rd(2'd2, v); chk("mask_upper_bits", v, 16'h000F);

    // Counter saturation on the fast-debounce instance
    for (int g = 0; g < 16383; g++) group2();
    repeat (4) @(negedge clk);
    rd2(2'd3, v); chk("sat_preload", v, 16'hFFFC);
    group2(); repeat (4) @(negedge clk);
    rd2(2'd3, v); chk("sat_reach", v, 16'hFFFF);
    group2(); repeat (4) @(negedge clk);
    rd2(2'd3, v); chk("sat_hold", v, 16'hFFFF);

    // Asynchronous reset in the middle of a debounce
    btn_raw = 4'b0000; repeat (8) @(negedge clk);
    wr(2'd1, 16'h000F);
    wr(2'd3, 16'h0000);
    wr(2'd2, 16'h0004);
    bus.cs = 1'b1; bus.we = 1'b0; bus.reg_sel = 2'd2;
    btn_raw = 4'b0100;
    for (int k = 1; k <= 4; k++) @(negedge clk);
    chk("pre_reset_out", bus.out, 16'h0004);
    reset = 1'b1;
    #1;
    chk("async_reset_out", bus.out, 16'h0000);
    chk("async_reset_irq", {15'h0, bus.irq}, 16'h0);
    repeat (2) @(negedge clk);
    bus.cs = 1'b0;
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) @(negedge clk);
    rd(2'd0, v); chk("post_reset_e6_read", v, 16'h0000);
    rd(2'd0, v); chk("post_reset_status", v, 16'h0004);
    rd(2'd1, v); chk("post_reset_pending", v, 16'h0004);
    rd(2'd3, v); chk("post_reset_evt", v, 16'h0001);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
